rdcla: RTL and testbench

RDCLA -- requirements
Module: rdcla

---
 rtl/rdcla_pkg.sv | 16 +
 rtl/rdcla_kpg_cell.sv | 19 +
 rtl/rdcla.sv | 89 ++++++++
 tb/tb_rdcla.sv | 118 +++++++++++
 4 files changed

// File: rtl/rdcla_pkg.sv
// Shared types and constants for the recursive-doubling carry-lookahead adder.
// kpg_t encodes per-bit carry status: K (carry killed), P (carry propagated),
// G (carry generated). K is all-zero, so a cleared rank reads as "no carry".
package rdcla_pkg;

  typedef enum logic [1:0] {
    K = 2'b00,
    P = 2'b01,
    G = 2'b10
  } kpg_t;

  localparam int unsigned RDCLA_WIDTH   = 32;
  localparam int unsigned RDCLA_STAGES  = $clog2(RDCLA_WIDTH);
  localparam int unsigned RDCLA_LATENCY = RDCLA_STAGES + 1;

endpackage

// File: rtl/rdcla_kpg_cell.sv
// Combinational K/P/G combine operator, one per bit per doubling stage.
// Ports:
//   hi    - status symbol of the higher-order span
//   lo    - status symbol of the adjacent lower-order span
//   res_c - combined status: lo when hi propagates, otherwise hi
module rdcla_kpg_cell
  import rdcla_pkg::*;
(
  input  logic [1:0] hi,
  input  logic [1:0] lo,
  output logic [1:0] res_c
);

  always_comb begin
    res_c = hi;
    if (hi == 2'(P)) res_c = lo;
  end

endmodule

// File: rtl/rdcla.sv
// Fully pipelined parallel-prefix (recursive-doubling) adder.
// One input rank, one rank per doubling stage, one output rank:
// operands sampled at edge k appear on sum/cout after edge k+STAGES+1.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset, clears every rank
//   a, b  - unsigned addends
//   cin   - carry-in
//   sum   - registered (a+b+cin) mod 2^WIDTH
//   cout  - registered carry-out of the top bit
module rdcla
  import rdcla_pkg::*;
#(
  parameter int unsigned WIDTH = RDCLA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned STAGES = $clog2(WIDTH);

  // sym_q[0] is the input rank; sym_q[s+1] is the rank after doubling stage s.
  logic [STAGES:0][WIDTH-1:0][1:0]   sym_q;
  logic [STAGES-1:0][WIDTH-1:0][1:0] nxt_c;
  logic [STAGES:0][WIDTH-1:0]        x_q;
  logic [STAGES:0]                   cin_q;

  logic [WIDTH-1:0][1:0] init_c;
  logic [WIDTH-1:0]      carry_c;

  // Initial per-bit status; bit 0 absorbs cin so it is never P, which
  // guarantees every prefix resolves to K or G after the last stage.
  always_comb begin
    for (int i = 1; i < WIDTH; i++) begin
      if (a[i] ^ b[i])  init_c[i] = 2'(P);
      else if (a[i])    init_c[i] = 2'(G);
      else              init_c[i] = 2'(K);
    end
    init_c[0] = ((a[0] & b[0]) | ((a[0] ^ b[0]) & cin)) ? 2'(G) : 2'(K);
  end

  // Doubling stage j combines each bit with the span 2^j positions below.
  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << j)) begin : g_cell
        rdcla_kpg_cell u_cell (
          .hi    (sym_q[j][i]),
          .lo    (sym_q[j][i - (1 << j)]),
          .res_c (nxt_c[j][i])
        );
      end else begin : g_pass
        assign nxt_c[j][i] = sym_q[j][i];
      end
    end
  end

  // Resolved prefix: carry out of bit i is set iff its status is G.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      carry_c[i] = (sym_q[STAGES][i] == 2'(G));
    end
  end

  // Pipeline ranks; a^b and cin travel alongside the symbols for the final XOR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_q <= '0;
      x_q   <= '0;
      cin_q <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      sym_q[0]        <= init_c;
      x_q[0]          <= a ^ b;
      cin_q[0]        <= cin;
      sym_q[STAGES:1] <= nxt_c;
      x_q[STAGES:1]   <= x_q[STAGES-1:0];
      cin_q[STAGES:1] <= cin_q[STAGES-1:0];
      sum             <= x_q[STAGES] ^ {carry_c[WIDTH-2:0], cin_q[STAGES]};
      cout            <= carry_c[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_rdcla.sv
// Self-checking bench for rdcla (WIDTH=32): directed vectors, streaming,
// mid-stream reset and random vectors against an arithmetic reference model.
module tb_rdcla;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 6;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;

  int total;
  int bad;
  string phase;

  // Expected {cout,sum} per sampling edge, oldest first.
  logic [W:0] expq[$];

  rdcla #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W:0] got, input logic [W:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got cout=%0b sum=%08h, expected cout=%0b sum=%08h",
               tag, got[W], got[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask

  // One clock: check output of the previous edge, then drive the next operands.
  task automatic tick(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tcin, input logic trst_n);
    logic [W:0] e;
    @(negedge clk);
    if (expq.size() > LAT) begin
      e = expq.pop_front();
      check_val(phase, {cout, sum}, e);
    end
    a     = ta;
    b     = tb_v;
    cin   = tcin;
    rst_n = trst_n;
    if (!trst_n) begin
      // Reset empties the pipe: every output until new operands arrive is 0.
      expq.delete();
      for (int i = 0; i <= LAT; i++) expq.push_back('0);
    end else begin
      expq.push_back({1'b0, ta} + {1'b0, tb_v} + (W+1)'(tcin));
    end
  endtask

  task automatic hold(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tcin, input int n);
    for (int i = 0; i < n; i++) tick(ta, tb_v, tcin, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    a = '0; b = '0; cin = 1'b0; rst_n = 1'b0;

    phase = "reset";
    tick(32'h0, 32'h0, 1'b0, 1'b0);
    tick(32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0);
    hold(32'h0, 32'h0, 1'b0, 8);

    phase = "full_carry";
    hold(32'hFFFFFFFF, 32'h00000001, 1'b0, 8);
    phase = "cin_ripple";
    hold(32'hFFFFFFFF, 32'h00000000, 1'b1, 8);
    phase = "msb_carry";
    hold(32'h80000000, 32'h80000000, 1'b0, 8);
    phase = "held_mix";
    hold(32'h12345678, 32'h9ABCDEF0, 1'b0, 10);

    phase = "stream";
    tick(32'd1, 32'd1, 1'b0, 1'b1);
    tick(32'd2, 32'd2, 1'b0, 1'b1);
    tick(32'd3, 32'd3, 1'b0, 1'b1);
    tick(32'd4, 32'd4, 1'b0, 1'b1);
    hold(32'h0, 32'h0, 1'b0, 8);

    phase = "mid_reset";
    tick(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    tick(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
    tick(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1);
    tick(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0);
    tick(32'd10, 32'd20, 1'b1, 1'b1);
    tick(32'd30, 32'd40, 1'b0, 1'b1);
    hold(32'h0, 32'h0, 1'b0, 8);

    phase = "random";
    for (int i = 0; i < 500; i++) begin
      tick($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    end
    phase = "drain";
    hold(32'h0, 32'h0, 1'b0, LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
